// File: rtl/dice_pkg.sv
// Shared definitions for the dice pool roller: die-select codes, the sides
// and draw-mask tables, FSM states and the 16-bit Galois LFSR constants.
package dice_pkg;

  typedef enum logic [2:0] {
    DIE_D4  = 3'd0,
    DIE_D6  = 3'd1,
    DIE_D8  = 3'd2,
    DIE_D10 = 3'd3,
    DIE_D12 = 3'd4,
    DIE_D20 = 3'd5
  } die_sel_e;

  // Highest legal die-select code; 6 and 7 are rejected.
  localparam logic [2:0] DIE_SEL_MAX = 3'(DIE_D20);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // One right-shift Galois step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Number of faces for a die-select code.
  function automatic logic [4:0] die_sides(input logic [2:0] sel);
    logic [4:0] sides;
    case (sel)
      DIE_D4:  sides = 5'd4;
      DIE_D6:  sides = 5'd6;
      DIE_D8:  sides = 5'd8;
      DIE_D10: sides = 5'd10;
      DIE_D12: sides = 5'd12;
      DIE_D20: sides = 5'd20;
      default: sides = 5'd1;
    endcase
    return sides;
  endfunction

  // Smallest all-ones mask covering every face index of the die.
  function automatic logic [4:0] die_mask(input logic [2:0] sel);
    logic [4:0] mask;
    case (sel)
      DIE_D4:           mask = 5'd3;
      DIE_D6, DIE_D8:   mask = 5'd7;
      DIE_D10, DIE_D12: mask = 5'd15;
      DIE_D20:          mask = 5'd31;
      default:          mask = 5'd0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dice_lfsr16.sv
// 16-bit Galois LFSR with seed load. A zero seed would lock the register,
// so it is replaced by the default seed. Only the low five bits leave the
// block since that is all a draw consumes.
module dice_lfsr16
  import dice_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [4:0]  draw_bits
);

  logic [15:0] state;

  // Load on request, otherwise advance one step every cycle.
  // NOTE: sequential state is written with <= so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LFSR_DEFAULT;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    end else begin
      state <= lfsr_next(state);
    end
  end

  assign draw_bits = state[4:0];

endmodule

// File: rtl/dice_pool_roller.sv
// Dice pool roller: on a valid roll request, draws dice_count faces of the
// selected die from the LFSR by rejection sampling, folding an out-of-range
// draw back into range once MAX_REJ consecutive draws have been rejected.
// Reports each accepted face and the final sum of the roll.
module dice_pool_roller
  import dice_pkg::*;
#(
  parameter int MAX_DICE = 4,
  parameter int MAX_REJ  = 8,
  parameter int SUM_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              seed_load,
  input  logic [15:0]                       seed,
  input  logic                              roll,
  input  logic [2:0]                        die_select,
  input  logic [$clog2(MAX_DICE+1)-1:0]     dice_count,
  output logic                              busy,
  output logic [4:0]                        die_value,
  output logic                              die_valid,
  output logic [SUM_W-1:0]                  sum,
  output logic                              result_valid,
  output logic                              err
);

  localparam int CNT_W = $clog2(MAX_DICE + 1);
  localparam int REJ_W = (MAX_REJ > 0) ? $clog2(MAX_REJ + 1) : 1;

  localparam logic [CNT_W-1:0] MAX_DICE_C = CNT_W'(MAX_DICE);
  localparam logic [REJ_W-1:0] MAX_REJ_C  = REJ_W'(MAX_REJ);

  state_e             state;
  logic [2:0]         sel_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   die_cnt;
  logic [REJ_W-1:0]   rej_cnt;
  logic [SUM_W-1:0]   acc;
  logic [4:0]         draw_bits;

  logic [4:0]         sides;
  logic [4:0]         mask;
  logic [4:0]         r;
  logic               hit;
  logic               fold;
  logic               accept;
  logic [4:0]         face;
  logic [CNT_W-1:0]   die_cnt_nxt;
  logic               last_die;
  logic [SUM_W-1:0]   acc_nxt;
  logic               req_ok;

  dice_lfsr16 u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load      (seed_load),
    .seed      (seed),
    .draw_bits (draw_bits)
  );

  // Evaluate the current draw: in-range hit, forced fold-back, resulting face.
  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    sides       = die_sides(sel_q);
    mask        = die_mask(sel_q);
    r           = draw_bits & mask;
    hit         = (r < sides);
    fold        = !hit && (rej_cnt == MAX_REJ_C);
    accept      = hit || fold;
    // The mask never exceeds twice the sides, so r - sides stays below sides.
    face        = hit ? (r + 5'd1) : (r - sides + 5'd1);
    die_cnt_nxt = die_cnt + CNT_W'(1);
    last_die    = accept && (die_cnt_nxt == count_q);
    acc_nxt     = acc + SUM_W'(face);
  end

  assign req_ok = (die_select <= DIE_SEL_MAX) &&
                  (dice_count != '0) &&
                  (dice_count <= MAX_DICE_C);

  assign busy = (state != ST_IDLE);

  // Request handling, draw sequencing and registered result pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      count_q      <= '0;
      die_cnt      <= '0;
      rej_cnt      <= '0;
      acc          <= '0;
      die_value    <= '0;
      die_valid    <= 1'b0;
      sum          <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      die_valid    <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A seed load takes the cycle; a roll alongside it is dropped.
          if (roll && !seed_load) begin
            if (req_ok) begin
              state   <= ST_DRAW;
              sel_q   <= die_select;
              count_q <= dice_count;
              die_cnt <= '0;
              rej_cnt <= '0;
              acc     <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_DRAW: begin
          if (accept) begin
            die_valid <= 1'b1;
            die_value <= face;
            rej_cnt   <= '0;
            die_cnt   <= die_cnt_nxt;
            acc       <= acc_nxt;
            if (last_die) begin
              sum          <= acc_nxt;
              result_valid <= 1'b1;
              state        <= ST_IDLE;
            end
          end else begin
            rej_cnt <= rej_cnt + REJ_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_pool_roller.sv
// Self-checking bench for dice_pool_roller: hand-derived vectors from the
// 0xACE1 seed, error/ignore/reset sequences, a fold-back case, and random
// rolls checked against a transaction-level model of the draw rules.
module tb_dice_pool_roller;

  localparam int MAX_DICE = 4;
  localparam int MAX_REJ  = 8;
  localparam int SUM_W    = 8;
  localparam int CW       = $clog2(MAX_DICE + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             seed_load;
  logic [15:0]      seed;
  logic             roll;
  logic [2:0]       die_select;
  logic [CW-1:0]    dice_count;
  logic             busy;
  logic [4:0]       die_value;
  logic             die_valid;
  logic [SUM_W-1:0] sum;
  logic             result_valid;
  logic             err;

  dice_pool_roller #(
    .MAX_DICE (MAX_DICE),
    .MAX_REJ  (MAX_REJ),
    .SUM_W    (SUM_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seed_load    (seed_load),
    .seed         (seed),
    .roll         (roll),
    .die_select   (die_select),
    .dice_count   (dice_count),
    .busy         (busy),
    .die_value    (die_value),
    .die_valid    (die_valid),
    .sum          (sum),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int sides_tab[6] = '{4, 6, 8, 10, 12, 20};

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Generator value tracked cycle by cycle from the inputs.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset)          m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
    else                m_lfsr <= lfsr_step(m_lfsr);
  end

  int exp_faces[$];
  int exp_sum;
  int exp_cycles;
  int exp_folds;

  // Whole-roll outcome given the generator value seen in the first draw cycle.
  task automatic model_roll(input logic [15:0] start, input int sel, input int cnt);
    logic [15:0] x;
    int sides;
    int mask;
    x     = start;
    sides = sides_tab[sel];
    mask  = (1 << $clog2(sides)) - 1;
    exp_faces.delete();
    exp_sum    = 0;
    exp_cycles = 0;
    exp_folds  = 0;
    for (int d = 0; d < cnt; d++) begin
      int misses;
      int face;
      misses = 0;
      face   = 0;
      while (face == 0) begin
        int rv;
        rv = int'(x[4:0]) & mask;
        exp_cycles++;
        if (rv < sides) face = rv + 1;
        else if (misses == MAX_REJ) begin
          face = rv - sides + 1;
          exp_folds++;
        end else misses++;
        x = lfsr_step(x);
      end
      exp_faces.push_back(face);
      exp_sum += face;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int got_faces[$];
  int last_sum;
  int last_face;
  int last_cyc;

  task automatic load_seed(input logic [15:0] s);
    seed      = s;
    seed_load = 1'b1;
    @(posedge clk); @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Issue a roll at the current negedge and check the full transaction.
  // With poke set, a bad request is presented during the first draw cycle.
  task automatic run_roll(input logic [2:0] sel, input int cnt, input bit poke, input string tag);
    logic [15:0] start;
    int cyc;
    bit done;
    int since;
    int max_gap;
    die_select = sel;
    dice_count = CW'(cnt);
    roll       = 1'b1;
    @(posedge clk); @(negedge clk);
    roll  = 1'b0;
    start = m_lfsr;
    check({tag, " busy after roll"}, 32'(busy), 1);
    check({tag, " no err on valid roll"}, 32'(err), 0);
    model_roll(start, int'(sel), cnt);
    if (poke) begin
      roll       = 1'b1;
      die_select = 3'd7;
    end
    got_faces.delete();
    cyc = 0; done = 0; since = 0; max_gap = 0; last_sum = -1; last_face = -1;
    while (!done && cyc < cnt * (MAX_REJ + 1) + 4) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      since++;
      if (poke && cyc == 1) begin
        check({tag, " roll while busy ignored"}, 32'(err), 0);
        roll = 1'b0;
      end
      if (die_valid) begin
        got_faces.push_back(int'(die_value));
        last_face = int'(die_value);
        if (since > max_gap) max_gap = since;
        since = 0;
      end
      if (result_valid) begin
        done     = 1;
        last_sum = int'(sum);
      end
    end
    last_cyc = cyc;
    check({tag, " result_valid seen"}, 32'(done), 1);
    check({tag, " draw cycles"}, 32'(cyc), 32'(exp_cycles));
    check({tag, " dice reported"}, 32'(got_faces.size()), 32'(exp_faces.size()));
    for (int i = 0; i < exp_faces.size() && i < got_faces.size(); i++) begin
      check($sformatf("%s face[%0d]", tag, i), 32'(got_faces[i]), 32'(exp_faces[i]));
      check($sformatf("%s face[%0d] in range", tag, i),
            32'(got_faces[i] >= 1 && got_faces[i] <= sides_tab[sel]), 1);
    end
    check({tag, " sum"}, 32'(last_sum), 32'(exp_sum));
    check({tag, " draws per die bound"}, 32'(max_gap <= MAX_REJ + 1), 1);
    check({tag, " idle after result"}, 32'(busy), 0);
  endtask

  task automatic bad_request(input logic [2:0] sel, input logic [CW-1:0] cnt, input string tag);
    die_select = sel;
    dice_count = cnt;
    roll       = 1'b1;
    @(posedge clk); @(negedge clk);
    roll = 1'b0;
    check({tag, " err pulse"}, 32'(err), 1);
    check({tag, " busy stays low"}, 32'(busy), 0);
    @(posedge clk); @(negedge clk);
    check({tag, " err one cycle"}, 32'(err), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " die_value"}, 32'(die_value), 0);
    check({tag, " die_valid"}, 32'(die_valid), 0);
    check({tag, " sum"}, 32'(sum), 0);
    check({tag, " result_valid"}, 32'(result_valid), 0);
    check({tag, " err"}, 32'(err), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] seed;
    logic [2:0]  sel;
    int          cnt;
    int          exp_sum;
    int          exp_last;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Draw sequence from 0xACE1: low five bits 16, 24, 28, 14, 7, 19, ...
    vecs[0] = '{16'hACE1, 3'd0, 1,  1,  1, 1};
    vecs[1] = '{16'hACE1, 3'd5, 1, 17, 17, 1};
    vecs[2] = '{16'hACE1, 3'd5, 2, 32, 15, 4};
    vecs[3] = '{16'hACE1, 3'd4, 2, 10,  9, 2};
    vecs[4] = '{16'hACE1, 3'd1, 3,  7,  5, 3};
    vecs[5] = '{16'hACE1, 3'd3, 4, 22,  4, 6};
    vecs[6] = '{16'h0000, 3'd5, 1, 17, 17, 1};

    reset = 1'b1; seed_load = 1'b0; seed = '0; roll = 1'b0;
    die_select = '0; dice_count = '0;

    repeat (3) @(negedge clk);
    check_quiet("in reset");
    reset = 1'b0;
    check_quiet("reset released");

    // First roll on the very first edge after release, default seed.
    run_roll(3'd0, 1, 0, "first roll");
    check("first roll hand sum", 32'(last_sum), 1);

    for (int i = 0; i < 7; i++) begin
      load_seed(vecs[i].seed);
      run_roll(vecs[i].sel, vecs[i].cnt, 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table sum", i), 32'(last_sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d table last face", i), 32'(last_face), 32'(vecs[i].exp_last));
      check($sformatf("vec%0d table cycles", i), 32'(last_cyc), 32'(vecs[i].exp_cyc));
    end

    // Rejected requests and seed_load overriding a roll.
    bad_request(3'd7, CW'(1), "sel7");
    bad_request(3'd6, CW'(2), "sel6");
    bad_request(3'd0, CW'(0), "count0");
    bad_request(3'd5, CW'(MAX_DICE + 1), "count over max");
    die_select = 3'd7; roll = 1'b1; seed = 16'h5555; seed_load = 1'b1;
    @(posedge clk); @(negedge clk);
    roll = 1'b0; seed_load = 1'b0;
    check("seed_load overrides roll err", 32'(err), 0);
    check("seed_load overrides roll busy", 32'(busy), 0);

    // Roll while busy is ignored.
    load_seed(16'h3C5A);
    run_roll(3'd5, 4, 1, "busy poke");
    @(posedge clk); @(negedge clk);
    check("no err after busy poke", 32'(err), 0);

    // Forced fold-back: find a seed whose first d20 die rejects MAX_REJ times.
    begin
      int found;
      found = -1;
      for (int s = 1; s < 65536 && found < 0; s++) begin
        model_roll(lfsr_step(16'(s)), 5, 1);
        if (exp_folds > 0) found = s;
      end
      check("fold seed found", 32'(found > 0), 1);
      if (found > 0) begin
        load_seed(16'(found));
        run_roll(3'd5, 1, 0, "fold d20");
        check("fold d20 takes max draws", 32'(last_cyc), 32'(MAX_REJ + 1));
      end
    end

    // Reset in the middle of a 4-die roll.
    load_seed(16'h1234);
    run_roll(3'd5, 2, 0, "pre reset");
    die_select = 3'd1; dice_count = CW'(4); roll = 1'b1;
    @(posedge clk); @(negedge clk);
    roll = 1'b0;
    check("mid roll busy", 32'(busy), 1);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet("mid roll reset");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check_quiet("after mid roll reset");
    run_roll(3'd1, 4, 0, "post reset roll");

    // Random seeds, max-size d6 pools.
    for (int k = 0; k < 1000; k++) begin
      load_seed(16'($urandom));
      run_roll(3'd1, MAX_DICE, 0, $sformatf("d6 rand%0d", k));
    end

    // Random die types and counts, seed carried over or reloaded.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1) load_seed(16'($urandom));
      run_roll(3'($urandom_range(0, 5)), int'($urandom_range(1, MAX_DICE)), 0,
               $sformatf("mix%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
